// File: rtl/pipelined_register_file.sv
// Register file with combinational read ports, optional write-through bypass,
// and per-register pending-write counters that drive issue hazard detection.
module pipelined_register_file #(
  parameter int unsigned  DWIDTH   = 32,
  parameter int unsigned  NREGS    = 32,
  parameter int unsigned  NUM_READ = 2,
  parameter int unsigned  BYPASS   = 1,
  parameter logic [31:0]  SP_INIT  = 32'h0100_0000,
  parameter int unsigned  CNT_W    = 2,
  localparam int unsigned AW       = $clog2(NREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_READ*AW-1:0]       rs_addr_i,
  output logic [NUM_READ*DWIDTH-1:0]   rs_data_o,
  input  logic [NUM_READ-1:0]          rs_used_i,
  input  logic [AW-1:0]                rd_i,
  input  logic [DWIDTH-1:0]            datawb_i,
  input  logic                         regwren_i,
  input  logic                         issue_valid_i,
  input  logic [AW-1:0]                issue_rd_i,
  input  logic                         issue_wr_i,
  input  logic                         flush_i,
  output logic                         hazard_o,
  output logic [NREGS-1:0]             busy_o
);

  logic [DWIDTH-1:0] regs_q [NREGS];
  logic [DWIDTH-1:0] regs_d [NREGS];
  logic [CNT_W-1:0]  cnt_q  [NREGS];
  logic [CNT_W-1:0]  cnt_d  [NREGS];

  logic                wr_en;
  logic                full;
  logic                accept;
  logic [NUM_READ-1:0] raw;

  assign wr_en = regwren_i && (rd_i != '0);

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          byp;
    assign a   = rs_addr_i[k*AW +: AW];
    assign byp = (BYPASS != 0) && wr_en && (rd_i == a);
    assign rs_data_o[k*DWIDTH +: DWIDTH] = (a == '0) ? '0 : (byp ? datawb_i : regs_q[a]);
    // A pending write that retires this very cycle (last outstanding) is forwarded, not stalled.
    assign raw[k] = rs_used_i[k] && (a != '0) && (cnt_q[a] != '0)
                    && !(byp && (cnt_q[a] == CNT_W'(1)));
  end

  assign full     = issue_wr_i && (issue_rd_i != '0) && (cnt_q[issue_rd_i] == '1);
  assign hazard_o = issue_valid_i && !flush_i && ((|raw) || full);
  assign accept   = issue_valid_i && !hazard_o && issue_wr_i && (issue_rd_i != '0);

  always_comb begin
    busy_o = '0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      busy_o[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < NREGS; r++) begin
      regs_d[r] = regs_q[r];
      cnt_d[r]  = cnt_q[r];
      if (wr_en && (rd_i == AW'(r))) begin
        regs_d[r] = datawb_i;
      end
      // Issue and writeback on the same register cancel; a lone writeback saturates at zero.
      if (flush_i) begin
        cnt_d[r] = '0;
      end else if (accept && (issue_rd_i == AW'(r)) && !(wr_en && (rd_i == AW'(r)))) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (!(accept && (issue_rd_i == AW'(r))) && wr_en && (rd_i == AW'(r))
                   && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= (r == 2) ? DWIDTH'(SP_INIT) : '0;
        cnt_q[r]  <= '0;
      end
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_register_file.sv
// Table-driven bench for pipelined_register_file: each row drives one cycle of
// stimulus and the expected combinational outputs are checked via a queue.
module tb_pipelined_register_file;

  localparam logic [31:0] SP = 32'h0100_0000;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr_i;
  logic [63:0] rs_data_o;
  logic [1:0]  rs_used_i;
  logic [4:0]  rd_i;
  logic [31:0] datawb_i;
  logic        regwren_i;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_i;
  logic        issue_wr_i;
  logic        flush_i;
  logic        hazard_o;
  logic [31:0] busy_o;

  pipelined_register_file #(
    .DWIDTH(32), .NREGS(32), .NUM_READ(2), .BYPASS(1),
    .SP_INIT(32'h0100_0000), .CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .rs_addr_i(rs_addr_i), .rs_data_o(rs_data_o),
    .rs_used_i(rs_used_i), .rd_i(rd_i), .datawb_i(datawb_i), .regwren_i(regwren_i),
    .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .issue_wr_i(issue_wr_i),
    .flush_i(flush_i), .hazard_o(hazard_o), .busy_o(busy_o)
  );

  typedef struct {
    logic        rst;
    logic [4:0]  ra0, ra1;
    logic [1:0]  used;
    logic        wren;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        iv, iwr;
    logic [4:0]  ird;
    logic        flush;
    logic        chk;
    logic [31:0] e0, e1;
    logic        ehz;
    logic [31:0] ebusy;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] e0, e1;
    logic        ehz;
    logic [31:0] ebusy;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   row   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic r, input logic [4:0] a0, input logic [4:0] a1,
                              input logic [1:0] u, input logic we, input logic [4:0] d,
                              input logic [31:0] w, input logic v, input logic iw,
                              input logic [4:0] ir, input logic fl, input logic c,
                              input logic [31:0] x0, input logic [31:0] x1,
                              input logic h, input logic [31:0] b);
    vec_t t;
    t.rst = r; t.ra0 = a0; t.ra1 = a1; t.used = u; t.wren = we; t.rd = d; t.wb = w;
    t.iv = v; t.iwr = iw; t.ird = ir; t.flush = fl; t.chk = c;
    t.e0 = x0; t.e1 = x1; t.ehz = h; t.ebusy = b;
    return t;
  endfunction

  task automatic check32(input string nm, input int idx, input logic [31:0] got,
                         input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL row%0d %s: got %h expected %h", idx, nm, got, want);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clk);
    #1;
    rst = v.rst; rs_addr_i = {v.ra1, v.ra0}; rs_used_i = v.used;
    regwren_i = v.wren; rd_i = v.rd; datawb_i = v.wb;
    issue_valid_i = v.iv; issue_wr_i = v.iwr; issue_rd_i = v.ird; flush_i = v.flush;
    if (v.chk) begin
      e.idx = row; e.e0 = v.e0; e.e1 = v.e1; e.ehz = v.ehz; e.ebusy = v.ebusy;
      exp_q.push_back(e);
    end
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check32("rs0",    e.idx, rs_data_o[31:0],  e.e0);
      check32("rs1",    e.idx, rs_data_o[63:32], e.e1);
      check32("hazard", e.idx, {31'd0, hazard_o}, {31'd0, e.ehz});
      check32("busy",   e.idx, busy_o,            e.ebusy);
    end
    row++;
  endtask

  initial begin
    rst = 1'b0; rs_addr_i = '0; rs_used_i = '0; rd_i = '0; datawb_i = '0;
    regwren_i = 1'b0; issue_valid_i = 1'b0; issue_rd_i = '0; issue_wr_i = 1'b0; flush_i = 1'b0;

    //            rst ra0 ra1 used  we rd wb             iv iw ird fl chk e0             e1             hz busy
    vecs.push_back(mk(1, 0,  0, 2'b00, 0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 2,  0, 2'b00, 0, 0, 32'h0,        0, 0, 0, 0, 1, SP,           32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 5,  2, 2'b00, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'hDEADBEEF, SP,           0, 32'h0));
    vecs.push_back(mk(0, 5,  5, 2'b00, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 32'h0));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        1, 1, 7, 0, 1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 7,  0, 2'b01, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h0,        32'h0,        1, 32'h80));
    vecs.push_back(mk(0, 7,  0, 2'b01, 1, 7, 32'h12345678, 1, 0, 0, 0, 1, 32'h12345678, 32'h0,        0, 32'h80));
    vecs.push_back(mk(0, 7,  7, 2'b00, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h12345678, 32'h12345678, 0, 32'h0));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        1, 1, 3, 0, 1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        1, 1, 3, 0, 1, 32'h0,        32'h0,        0, 32'h8));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        1, 1, 3, 0, 1, 32'h0,        32'h0,        0, 32'h8));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        1, 1, 3, 0, 1, 32'h0,        32'h0,        1, 32'h8));
    vecs.push_back(mk(0, 3,  0, 2'b00, 1, 3, 32'hAAAA0003, 0, 0, 0, 0, 1, 32'hAAAA0003, 32'h0,        0, 32'h8));
    vecs.push_back(mk(0, 3,  0, 2'b01, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'hAAAA0003, 32'h0,        1, 32'h8));
    vecs.push_back(mk(0, 3,  0, 2'b01, 1, 3, 32'hAAAA0004, 1, 0, 0, 0, 1, 32'hAAAA0004, 32'h0,        1, 32'h8));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        1, 1, 9, 0, 1, 32'h0,        32'h0,        0, 32'h8));
    vecs.push_back(mk(0, 9,  0, 2'b00, 1, 9, 32'h99,       1, 1, 9, 0, 1, 32'h99,       32'h0,        0, 32'h208));
    vecs.push_back(mk(0, 3, 12, 2'b01, 1, 12, 32'hC0C0C0C0, 1, 0, 0, 1, 1, 32'hAAAA0004, 32'hC0C0C0C0, 0, 32'h208));
    vecs.push_back(mk(0, 12, 9, 2'b00, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'hC0C0C0C0, 32'h99,       0, 32'h0));
    vecs.push_back(mk(0, 0,  0, 2'b00, 1, 0, 32'hFFFFFFFF, 1, 1, 0, 0, 1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        0, 0, 0, 0, 1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 0,  0, 2'b00, 0, 0, 32'h0,        1, 1, 4, 0, 1, 32'h0,        32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 4,  0, 2'b10, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h0,        32'h0,        0, 32'h10));
    vecs.push_back(mk(0, 0,  4, 2'b10, 0, 0, 32'h0,        1, 0, 0, 0, 1, 32'h0,        32'h0,        1, 32'h10));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset with a pending counter and a concurrent write/issue; then writebacks must not underflow.
    apply(mk(1, 6, 4, 2'b00, 1, 6, 32'h66, 1, 1, 5, 0, 1, 32'h66, 32'h0, 0, 32'h10));
    apply(mk(0, 6, 2, 2'b00, 0, 0, 32'h0,  0, 0, 0, 0, 1, 32'h0,  SP,    0, 32'h0));
    apply(mk(0, 4, 0, 2'b00, 1, 4, 32'h44, 0, 0, 0, 0, 1, 32'h44, 32'h0, 0, 32'h0));
    apply(mk(0, 4, 0, 2'b00, 0, 0, 32'h0,  1, 1, 4, 0, 1, 32'h44, 32'h0, 0, 32'h0));
    apply(mk(0, 4, 0, 2'b01, 0, 0, 32'h0,  1, 0, 0, 0, 1, 32'h44, 32'h0, 1, 32'h10));
    apply(mk(0, 4, 0, 2'b01, 1, 4, 32'h45, 1, 0, 0, 0, 1, 32'h45, 32'h0, 0, 32'h10));
    apply(mk(0, 4, 0, 2'b00, 0, 0, 32'h0,  0, 0, 0, 0, 1, 32'h45, 32'h0, 0, 32'h0));

    // Saturated counter: a same-cycle writeback does not lift the full stall; flush clears it.
    apply(mk(0, 0, 0, 2'b00, 0, 0, 32'h0,  1, 1, 8, 0, 1, 32'h0,  32'h0, 0, 32'h0));
    apply(mk(0, 0, 0, 2'b00, 0, 0, 32'h0,  1, 1, 8, 0, 1, 32'h0,  32'h0, 0, 32'h100));
    apply(mk(0, 0, 0, 2'b00, 0, 0, 32'h0,  1, 1, 8, 0, 1, 32'h0,  32'h0, 0, 32'h100));
    apply(mk(0, 0, 0, 2'b00, 1, 8, 32'h88, 1, 1, 8, 0, 1, 32'h0,  32'h0, 1, 32'h100));
    apply(mk(0, 8, 0, 2'b00, 0, 0, 32'h0,  1, 1, 8, 1, 1, 32'h88, 32'h0, 0, 32'h100));
    apply(mk(0, 8, 0, 2'b00, 0, 0, 32'h0,  0, 0, 0, 0, 1, 32'h88, 32'h0, 0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
